// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block sequencing controller.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_OUT,
        ST_FIN
    } state_e;

    localparam int unsigned SHA_ROUNDS       = 64;
    localparam int unsigned SHA_BLK_WORDS    = 16;
    localparam int unsigned SHA256_DIG_WORDS = 8;
    localparam int unsigned SHA224_DIG_WORDS = 7;

    typedef logic [5:0] round_cnt_t;
    typedef logic [3:0] load_cnt_t;
    typedef logic [2:0] out_cnt_t;

endpackage

// File: rtl/sha256_blk_ctrl.sv
// Sequencing FSM for one SHA-256 compression pass: load 16 words, 64 rounds, H update, digest stream.
// Optional SHA224_MODE_EN adds mode224_i / iv_sel_o and a 7-word digest when SHA-224 is selected.
module sha256_blk_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned LOAD_WORDS = SHA_BLK_WORDS,
    parameter int unsigned ROUNDS     = SHA_ROUNDS,
    parameter int unsigned OUT_WORDS  = SHA256_DIG_WORDS
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       first_blk_i,
    input  logic       last_blk_i,
`ifdef SHA224_MODE_EN
    input  logic       mode224_i,
    output logic       iv_sel_o,
`endif
    input  logic       msg_valid_i,
    output logic       msg_ready_o,
    output logic       h_init_o,
    output logic       wv_load_o,
    output logic       w_load_o,
    output logic       round_en_o,
    output logic [5:0] round_o,
    output logic       h_update_o,
    output logic [2:0] dout_sel_o,
    output logic       dout_valid_o,
    input  logic       dout_ready_i,
    output logic       dout_last_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam load_cnt_t  LOAD_LAST  = load_cnt_t'(LOAD_WORDS - 1);
    localparam round_cnt_t ROUND_LAST = round_cnt_t'(ROUNDS - 1);
    localparam out_cnt_t   OUT_LAST   = out_cnt_t'(OUT_WORDS - 1);

    state_e     state_q, state_d;
    load_cnt_t  load_q, load_d;
    round_cnt_t round_q, round_d;
    out_cnt_t   out_q, out_d;
    logic       first_q, first_d;
    logic       last_q, last_d;
    logic       wv_q, wv_d;
    out_cnt_t   out_last;

`ifdef SHA224_MODE_EN
    localparam out_cnt_t OUT_LAST_224 = out_cnt_t'(SHA224_DIG_WORDS - 1);
    logic mode_q, mode_d;

    assign out_last = mode_q ? OUT_LAST_224 : OUT_LAST;
    assign iv_sel_o = mode_q;
`else
    assign out_last = OUT_LAST;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            load_q  <= '0;
            round_q <= '0;
            out_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            wv_q    <= 1'b0;
`ifdef SHA224_MODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            round_q <= round_d;
            out_q   <= out_d;
            first_q <= first_d;
            last_q  <= last_d;
            wv_q    <= wv_d;
`ifdef SHA224_MODE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        round_d      = round_q;
        out_d        = out_q;
        first_d      = first_q;
        last_d       = last_q;
        wv_d         = 1'b0;
`ifdef SHA224_MODE_EN
        mode_d       = mode_q;
`endif
        msg_ready_o  = 1'b0;
        h_init_o     = 1'b0;
        round_en_o   = 1'b0;
        h_update_o   = 1'b0;
        dout_valid_o = 1'b0;
        dout_last_o  = 1'b0;
        done_o       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    first_d = first_blk_i;
                    last_d  = last_blk_i;
`ifdef SHA224_MODE_EN
                    mode_d  = mode224_i;
`endif
                    load_d  = '0;
                    round_d = '0;
                    out_d   = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                // Working-variable load is deferred one cycle so a freshly written IV is visible.
                h_init_o = first_q;
                wv_d     = 1'b1;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                msg_ready_o = 1'b1;
                if (msg_valid_i) begin
                    if (load_q == LOAD_LAST) state_d = ST_ROUND;
                    else                     load_d  = load_q + 1'b1;
                end
            end
            ST_ROUND: begin
                round_en_o = 1'b1;
                if (round_q == ROUND_LAST) begin
                    round_d = '0;
                    state_d = ST_UPDATE;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            ST_UPDATE: begin
                h_update_o = 1'b1;
                state_d    = last_q ? ST_OUT : ST_FIN;
            end
            ST_FIN: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_OUT: begin
                dout_valid_o = 1'b1;
                dout_last_o  = (out_q == out_last);
                if (dout_ready_i) begin
                    if (out_q == out_last) begin
                        done_o  = 1'b1;
                        out_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wv_load_o  = wv_q;
    assign w_load_o   = msg_valid_i & msg_ready_o;
    assign round_o    = round_q;
    assign dout_sel_o = out_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
